// File: rtl/layer_seq.sv
// layer_seq: per-layer phase sequencer for batch_ctrl.
// Walks weight load, bias load and sample streaming, then waits for the output stream to drain.
module layer_seq #(
   parameter int NW    = 16,
   parameter int NS    = 12,
   parameter int GAP   = 2,
   parameter int DRAIN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [2:0]    c_mode,
   input  logic [NW-1:0] c_wwords,
   input  logic [NW-1:0] c_bwords,
   input  logic [NS-1:0] c_nsamp,
   input  logic          src_valid,
   input  logic          src_ready,
   input  logic          dst_valid,
   input  logic          s_fin,
   input  logic          p_fin,
   output logic          run,
   output logic          pool,
   output logic          wwrite,
   output logic          bwrite,
   output logic          backprop,
   output logic          deltaw,
   output logic          dwconv,
   output logic          last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WLOAD = 3'd1;
   localparam logic [2:0] S_GAPW  = 3'd2;
   localparam logic [2:0] S_BLOAD = 3'd3;
   localparam logic [2:0] S_GAPB  = 3'd4;
   localparam logic [2:0] S_RUN   = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam logic [2:0] S_FIN   = 3'd7;

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int QW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
   localparam logic [QW-1:0] QUIET_LAST = QW'(DRAIN - 1);
   localparam logic [NW-1:0] W_ONE      = NW'(1);
   localparam logic [NS-1:0] S_ONE      = NS'(1);

   logic [2:0]    state_q, state_d;
   logic [NW-1:0] lcnt_q, lcnt_d;
   logic [NS-1:0] scnt_q, scnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [NW-1:0] wwords_q, wwords_d;
   logic [NW-1:0] bwords_q, bwords_d;
   logic [NS-1:0] nsamp_q, nsamp_d;
   logic          pool_m_q, pool_m_d;
   logic          bp_q, bp_d;
   logic          dw_q, dw_d;
   logic          dwc_q, dwc_d;
   logic          err_q, err_d;

   logic          beat;
   logic          fin;
   logic          in_run;
   logic [2:0]    after_w;
   logic [2:0]    after_b;
   logic [2:0]    first_state;

   // A zero GAP collapses each gap state straight into the following phase.
   function automatic logic [2:0] enter_gap(input logic [2:0] gap_state, input logic [2:0] next_state);
      return (GAP == 0) ? next_state : gap_state;
   endfunction

   always_comb begin
      beat        = src_valid & src_ready;
      fin         = pool_m_q ? p_fin : s_fin;
      after_b     = (nsamp_q != '0) ? S_RUN : S_FIN;
      after_w     = (bwords_q != '0) ? S_BLOAD : after_b;
      first_state = (c_wwords != '0) ? S_WLOAD :
                    (c_bwords != '0) ? S_BLOAD :
                    (c_nsamp  != '0) ? S_RUN   : S_FIN;

      state_d  = state_q;
      lcnt_d   = lcnt_q;
      scnt_d   = scnt_q;
      gcnt_d   = gcnt_q;
      qcnt_d   = qcnt_q;
      wwords_d = wwords_q;
      bwords_d = bwords_q;
      nsamp_d  = nsamp_q;
      pool_m_d = pool_m_q;
      bp_d     = bp_q;
      dw_d     = dw_q;
      dwc_d    = dwc_q;
      err_d    = err_q;

      if (start && (state_q != S_IDLE)) begin
         err_d = 1'b1;
      end

      if (abort) begin
         state_d  = S_IDLE;
         lcnt_d   = '0;
         scnt_d   = '0;
         gcnt_d   = '0;
         qcnt_d   = '0;
         pool_m_d = 1'b0;
         bp_d     = 1'b0;
         dw_d     = 1'b0;
         dwc_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  wwords_d = c_wwords;
                  bwords_d = c_bwords;
                  nsamp_d  = c_nsamp;
                  pool_m_d = (c_mode == 3'd4);
                  bp_d     = (c_mode == 3'd1);
                  dw_d     = (c_mode == 3'd2);
                  dwc_d    = (c_mode == 3'd3);
                  err_d    = 1'b0;
                  lcnt_d   = '0;
                  scnt_d   = '0;
                  gcnt_d   = '0;
                  qcnt_d   = '0;
                  state_d  = first_state;
               end
            end
            S_WLOAD: begin
               if (beat) begin
                  if (lcnt_q == wwords_q - W_ONE) begin
                     lcnt_d  = '0;
                     state_d = enter_gap(S_GAPW, after_w);
                  end else begin
                     lcnt_d = lcnt_q + W_ONE;
                  end
               end
            end
            S_GAPW: begin
               if (gcnt_q == GAP_LAST) begin
                  gcnt_d  = '0;
                  state_d = after_w;
               end else begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
            S_BLOAD: begin
               if (beat) begin
                  if (lcnt_q == bwords_q - W_ONE) begin
                     lcnt_d  = '0;
                     state_d = enter_gap(S_GAPB, after_b);
                  end else begin
                     lcnt_d = lcnt_q + W_ONE;
                  end
               end
            end
            S_GAPB: begin
               if (gcnt_q == GAP_LAST) begin
                  gcnt_d  = '0;
                  state_d = after_b;
               end else begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
            // The final fin leaves scnt at nsamp-1 so 'last' holds through DRAIN.
            S_RUN: begin
               if (fin) begin
                  if (scnt_q == nsamp_q - S_ONE) begin
                     qcnt_d  = '0;
                     state_d = S_DRAIN;
                  end else begin
                     scnt_d = scnt_q + S_ONE;
                  end
               end
            end
            S_DRAIN: begin
               if (dst_valid) begin
                  qcnt_d = '0;
               end else if (qcnt_q == QUIET_LAST) begin
                  qcnt_d  = '0;
                  state_d = S_FIN;
               end else begin
                  qcnt_d = qcnt_q + 1'b1;
               end
            end
            S_FIN: begin
               scnt_d   = '0;
               pool_m_d = 1'b0;
               bp_d     = 1'b0;
               dw_d     = 1'b0;
               dwc_d    = 1'b0;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lcnt_q   <= '0;
         scnt_q   <= '0;
         gcnt_q   <= '0;
         qcnt_q   <= '0;
         wwords_q <= '0;
         bwords_q <= '0;
         nsamp_q  <= '0;
         pool_m_q <= 1'b0;
         bp_q     <= 1'b0;
         dw_q     <= 1'b0;
         dwc_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lcnt_q   <= lcnt_d;
         scnt_q   <= scnt_d;
         gcnt_q   <= gcnt_d;
         qcnt_q   <= qcnt_d;
         wwords_q <= wwords_d;
         bwords_q <= bwords_d;
         nsamp_q  <= nsamp_d;
         pool_m_q <= pool_m_d;
         bp_q     <= bp_d;
         dw_q     <= dw_d;
         dwc_q    <= dwc_d;
         err_q    <= err_d;
      end
   end

   assign in_run   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign run      = in_run & ~pool_m_q;
   assign pool     = in_run & pool_m_q;
   assign wwrite   = (state_q == S_WLOAD);
   assign bwrite   = (state_q == S_BLOAD);
   assign backprop = bp_q;
   assign deltaw   = dw_q;
   assign dwconv   = dwc_q;
   assign last     = in_run & (scnt_q == nsamp_q - S_ONE);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_FIN);
   assign err      = err_q;

endmodule
